// File: rtl/stream_packer_2to1.sv
// Packs pairs of narrow stream beats into one double-width beat, low half first.
// A flush drains a lone held half as a partial beat with its upper strobes cleared.
module stream_packer_2to1 #(
    parameter int IN_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                flush_i,
    input  logic [IN_W-1:0]     in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W/8-1:0]   in_strb,
    output logic [2*IN_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IN_W/4-1:0]   out_strb,
    output logic [CNT_W-1:0]    words_o,
    output logic                busy_o
);

    localparam int SW = IN_W / 8;

    typedef enum logic {EMPTY, HALF} state_t;

    state_t              state_q;
    logic [IN_W-1:0]     lo_data_q;
    logic [SW-1:0]       lo_strb_q;
    logic [2*IN_W-1:0]   out_data_q;
    logic [2*SW-1:0]     out_strb_q;
    logic                out_valid_q;
    logic [CNT_W-1:0]    words_q;

    logic accept;
    logic out_free;
    logic out_hs;

    // Only out_ready reaches in_ready combinationally; EMPTY can always absorb one beat.
    assign out_free = ~out_valid_q | out_ready;
    assign in_ready = (state_q == EMPTY) | out_free;
    assign accept   = in_valid & in_ready;
    assign out_hs   = out_valid_q & out_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i | clear_i) begin
            state_q     <= EMPTY;
            lo_data_q   <= '0;
            lo_strb_q   <= '0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_valid_q <= 1'b0;
            words_q     <= '0;
        end else begin
            if (out_hs) begin
                out_valid_q <= 1'b0;
                words_q     <= words_q + 1'b1;
            end
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        lo_data_q <= in_data;
                        lo_strb_q <= in_strb;
                        state_q   <= HALF;
                    end
                end
                HALF: begin
                    // A beat arriving with flush completes the word; flush then has nothing to drain.
                    if (accept) begin
                        out_data_q  <= {in_data, lo_data_q};
                        out_strb_q  <= {in_strb, lo_strb_q};
                        out_valid_q <= 1'b1;
                        state_q     <= EMPTY;
                    end else if (flush_i && out_free) begin
                        out_data_q  <= {{IN_W{1'b0}}, lo_data_q};
                        out_strb_q  <= {{SW{1'b0}}, lo_strb_q};
                        out_valid_q <= 1'b1;
                        state_q     <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_strb  = out_strb_q;
    assign out_valid = out_valid_q;
    assign words_o   = words_q;
    assign busy_o    = (state_q == HALF) | out_valid_q;

endmodule

// File: tb/tb_stream_packer_2to1.sv
// Randomized and directed bench for stream_packer_2to1 with a queue-based reference model.
// Expected packed beats are pushed by the model and popped by an independent monitor.
module tb_stream_packer_2to1;

    localparam int IN_W  = 16;
    localparam int CNT_W = 16;

    logic              clk_i = 0;
    logic              rst_i = 1;
    logic              clear_i = 0;
    logic              flush_i = 0;
    logic [15:0]       in_data = 0;
    logic              in_valid = 0;
    logic              in_ready;
    logic [1:0]        in_strb = 0;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready = 0;
    logic [3:0]        out_strb;
    logic [15:0]       words_o;
    logic              busy_o;

    stream_packer_2to1 #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .flush_i(flush_i),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_strb(in_strb),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_strb(out_strb), .words_o(words_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: held narrow beats, the word sitting at the output, handoff count.
    logic [17:0] pend_q[$];   // {strb, data}
    logic [35:0] exp_q[$];    // {strb, data} of words in flight to the sink
    int          m_out_cnt = 0;
    int unsigned m_words = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_i) begin
        logic        exp_ir, acc;
        logic [17:0] a, b;
        if (rst_i || clear_i) begin
            pend_q.delete();
            exp_q.delete();
            m_out_cnt = 0;
            m_words   = 0;
        end else begin
            exp_ir = (pend_q.size() == 0) || (m_out_cnt == 0) || out_ready;
            chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
            acc = in_valid && exp_ir;
            if (m_out_cnt != 0 && out_ready) begin
                m_out_cnt--;
                m_words++;
            end
            if (acc) pend_q.push_back({in_strb, in_data});
            if (pend_q.size() == 2) begin
                a = pend_q.pop_front();
                b = pend_q.pop_front();
                exp_q.push_back({b[17:16], a[17:16], b[15:0], a[15:0]});
                m_out_cnt++;
            end else if (!acc && flush_i && pend_q.size() == 1 && (m_out_cnt == 0 || out_ready)) begin
                a = pend_q.pop_front();
                exp_q.push_back({2'b00, a[17:16], 16'h0000, a[15:0]});
                m_out_cnt++;
            end
        end
    end

    // Monitor: consume expected words on each output handshake.
    always @(posedge clk_i) begin
        logic [35:0] e;
        if (!rst_i && !clear_i && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {32'd0, out_data}, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("hs_data", {32'd0, out_data}, {32'd0, e[31:0]});
                chk("hs_strb", {60'd0, out_strb}, {60'd0, e[35:32]});
            end
        end
    end

    // Steady-state checks between edges.
    always @(negedge clk_i) begin
        if (!rst_i && !clear_i) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_out_cnt != 0});
            chk("words_o", {48'd0, words_o}, {48'd0, m_words[15:0]});
            chk("busy_o", {63'd0, busy_o}, {63'd0, (pend_q.size() != 0) || (m_out_cnt != 0)});
            if (out_valid) begin
                if (exp_q.size() == 0) chk("held_beat", {32'd0, out_data}, 64'hDEAD);
                else chk("held_data", {32'd0, out_data}, {32'd0, exp_q[0][31:0]});
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] d, input logic [1:0] s,
                        input logic f, input logic r);
        in_valid = v; in_data = d; in_strb = s; flush_i = f; out_ready = r;
        @(negedge clk_i);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        rst_i = 0;
        // reset state
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_strb", {60'd0, out_strb}, 64'd0);
        chk("rst_words", {48'd0, words_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // basic pair
        step(1, 16'h1111, 2'b11, 0, 1);
        chk("pair_no_early_valid", {63'd0, out_valid}, 64'd0);
        step(1, 16'h2222, 2'b11, 0, 1);
        chk("pair_data", {32'd0, out_data}, 64'h2222_1111);
        chk("pair_strb", {60'd0, out_strb}, 64'hF);
        step(0, 0, 0, 0, 1);
        chk("pair_words", {48'd0, words_o}, 64'd1);

        // back-to-back stream
        for (int i = 1; i <= 8; i++) step(1, 16'(i), 2'b11, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("stream_words", {48'd0, words_o}, 64'd5);

        // flush of a lone half, held 3 cycles
        step(1, 16'hABCD, 2'b01, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("flush_data", {32'd0, out_data}, 64'h0000_ABCD);
        chk("flush_strb", {60'd0, out_strb}, 64'h1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("flush_once", {48'd0, words_o}, 64'd6);
        step(1, 16'h3333, 2'b11, 0, 1);
        step(1, 16'h4444, 2'b10, 0, 1);
        chk("after_flush_data", {32'd0, out_data}, 64'h4444_3333);
        step(0, 0, 0, 0, 1);

        // backpressure
        step(1, 16'hA001, 2'b11, 0, 0);
        step(1, 16'hA002, 2'b11, 0, 0);
        step(1, 16'hA003, 2'b11, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 16'hA004, 2'b11, 0, 0);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_stable", {32'd0, out_data}, 64'hA002_A001);
        end
        step(1, 16'hA004, 2'b11, 0, 1);
        chk("bp_second", {32'd0, out_data}, 64'hA004_A003);
        step(0, 0, 0, 0, 1);

        // accept beats flush in HALF
        step(1, 16'h7777, 2'b11, 0, 1);
        step(1, 16'h5555, 2'b11, 1, 1);
        chk("acc_flush_data", {32'd0, out_data}, 64'h5555_7777);
        chk("acc_flush_strb", {60'd0, out_strb}, 64'hF);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);

        // clear with a word stalled and a half held
        step(1, 16'hC001, 2'b11, 0, 0);
        step(1, 16'hC002, 2'b11, 0, 0);
        step(1, 16'hC003, 2'b11, 0, 0);
        clear_i = 1;
        step(0, 0, 0, 0, 0);
        clear_i = 0;
        chk("clr_out_valid", {63'd0, out_valid}, 64'd0);
        chk("clr_busy", {63'd0, busy_o}, 64'd0);
        chk("clr_words", {48'd0, words_o}, 64'd0);
        chk("clr_in_ready", {63'd0, in_ready}, 64'd1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        chk("clr_no_emit", {48'd0, words_o}, 64'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            clear_i = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
        end
        clear_i = 0;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);
        chk("drain_empty", {32'd0, 32'(exp_q.size())}, 64'd0);
        chk("drain_idle", {63'd0, busy_o}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_packer_2to1.md
# stream_packer_2to1

Width-doubling stream stage sitting directly downstream of the actor-side output wrapper (16-bit data/valid/ready/strb stream). It packs pairs of consecutive narrow beats into one double-width beat for the HWPE streamer sink. A flush input drains a dangling half-word as a partial beat with its upper strobes cleared. All outputs are registered, and a running word counter is provided for the control slave.

## Interface
Parameters:
- IN_W, 16, narrow input data width in bits (multiple of 8)
- CNT_W, 16, width of emitted-word counter

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- clear_i  in  1  synchronous soft clear, same effect as rst_i
- flush_i  in  1  level drain request; emits held half-word as a partial beat
- in_data  in  IN_W  narrow beat data
- in_valid  in  1  narrow beat valid
- in_ready  out  1  narrow beat ready
- in_strb  in  IN_W/8  byte strobes of narrow beat
- out_data  out  2*IN_W  packed beat; first-accepted narrow beat in [IN_W-1:0]
- out_valid  out  1  packed beat valid
- out_ready  in  1  packed beat ready
- out_strb  out  IN_W/4  {hi_strb, lo_strb}
- words_o  out  CNT_W  count of packed beats handed off (out_valid & out_ready), wraps
- busy_o  out  1  half-word held or out_valid high

## Operation
- States: EMPTY (no low half held), HALF (low half + strobes held in lo register).
- in_ready = (state==EMPTY) | ~out_valid | out_ready; it never depends on in_valid, in_data or flush_i.
- Accept = in_valid & in_ready.
- EMPTY + accept: capture data/strb into lo; go to HALF. The output register is untouched.
- HALF + accept: load out_data={in_data, lo}, out_strb={in_strb, lo_strb}, out_valid=1; go to EMPTY.
- HALF, no accept, flush_i=1, output free (~out_valid | out_ready): load out_data={0, lo}, out_strb={0, lo_strb}, out_valid=1; go to EMPTY.
- Simultaneous accept and flush in HALF: the accept wins and a full word is formed. Flush then has nothing to drain that cycle.
- flush_i in EMPTY: no effect. A flush held across several cycles drains only the current half-word. New beats accepted afterwards pair normally.
- Output handshake: out_valid & out_ready clears out_valid unless a new word loads in the same cycle. out_data and out_strb stay stable while out_valid & ~out_ready.
- words_o increments by 1 on each out handshake and wraps modulo 2^CNT_W.
- rst_i or clear_i (the two are ORed) forces state=EMPTY, out_valid=0, out_data=0, out_strb=0, lo=0, words_o=0. This takes priority over all handshakes in the same cycle.
- A clear mid-word discards the held half and any unconsumed output word. No beat is emitted.

## Timing
- Reset values: out_valid=0, out_data=0, out_strb=0, words_o=0, busy_o=0, in_ready=1.
- Latency: the packed word appears (out_valid=1) on the cycle after the accept of its second narrow beat or after the flush cycle.
- Throughput: one narrow beat per cycle sustained while out_ready=1, giving one packed beat every 2 cycles.
- Backpressure: in HALF with out_valid=1 and out_ready=0, in_ready=0. In EMPTY, in_ready stays 1 even under backpressure, so one extra beat can be absorbed.
- No combinational path from in_valid/in_data to out_*. The only combinational path is out_ready -> in_ready.

## Test plan
- Reset then beats 0x1111/0x2222 with strb 2'b11 each, out_ready=1 -> next cycle out_data=0x2222_1111, out_strb=4'hF, words_o=1 after handshake.
- Stream 0x0001..0x0008 back-to-back with out_ready=1 -> 4 words 0x0002_0001, 0x0004_0003, 0x0006_0005, 0x0008_0007, one every 2 cycles, in_ready constantly 1.
- Beat 0xABCD strb 2'b01, then flush_i=1 for 3 cycles -> exactly one beat out_data=0x0000_ABCD, out_strb=4'b0001. A following beat pair packs normally.
- Hold out_ready=0 with a word pending: in EMPTY, one more beat is accepted, then in_ready=0. out_data is stable for 10 cycles. Raising out_ready releases both words in order.
- HALF state with in_valid=1 (0x5555) and flush_i=1 in the same cycle -> full word {0x5555, lo} with strb 4'hF, no partial beat.
- clear_i asserted in HALF with out_valid=1, out_ready=0 -> next cycle out_valid=0, busy_o=0, words_o=0, in_ready=1. The held half is never emitted.
